// File: rtl/i2s_sample_rx.sv
// i2s_sample_rx
// Upstream front end of the FFT path. Generates the I2S bit clock and word
// select for a single MEMS microphone and deserialises one slot. Each sample
// is presented as a 32-bit complex word: real in [31:16], imaginary zero.
// Everything runs in the clk domain.
//
// Ports:
//   clk           in   system clock (48 MHz nominal)
//   reset         in   asynchronous, active-high reset
//   en            in   run enable; low holds the interface idle
//   sd            in   serial data from the microphone (asynchronous)
//   bclk          out  I2S bit clock (half-period BCLK_DIV clk cycles)
//   ws            out  I2S word select (0 = left slot, 1 = right slot)
//   sample_out    out  {real[15:0], 16'h0000}
//   sample_valid  out  one-clk pulse when sample_out is new
//
// Parameters:
//   BCLK_DIV      bclk half-period in clk cycles (>= 2)
//   SAMPLE_BITS   significant bits per slot (16..24)
//   CHANNEL       captured slot: 0 = left, 1 = right
//
// Build option:
//   I2S_DC_BLOCK_EN  when defined, a first-order DC-removal filter sits
//                    between truncation and the output, adding one clk of
//                    latency. Undefined: the truncated sample goes straight
//                    to the output.

module i2s_sample_rx #(
   parameter int unsigned BCLK_DIV    = 16,
   parameter int unsigned SAMPLE_BITS = 18,
   parameter int unsigned CHANNEL     = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        sd,
   output logic        bclk,
   output logic        ws,
   output logic [31:0] sample_out,
   output logic        sample_valid
);

   localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam int unsigned TRUNC = SAMPLE_BITS - 16;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [4:0]       POS_LAST = 5'(SAMPLE_BITS);
   localparam logic             SLOT_SEL = 1'(CHANNEL);

   logic                   sd_meta;
   logic                   sd_sync;
   logic [DIV_W-1:0]       div_cnt;
   logic [5:0]             bit_cnt;
   // Holds the first SAMPLE_BITS-1 bits; the final bit joins combinationally
   // on the completing rise event.
   logic [SAMPLE_BITS-2:0] shreg;

   logic                   tick_c;
   logic                   rise_c;
   logic                   fall_c;
   logic                   in_slot_c;
   logic                   capture_c;
   logic                   done_c;
   logic [5:0]             bit_cnt_next_c;
   logic [SAMPLE_BITS-1:0] word_c;
   logic [15:0]            real_c;

   // Two-flop synchroniser for the asynchronous microphone data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sd_meta <= 1'b0;
         sd_sync <= 1'b0;
      end else begin
         sd_meta <= sd;
         sd_sync <= sd_meta;
      end
   end

   // Divider events, slot decode and word assembly.
   always_comb begin
      tick_c         = 1'b0;
      rise_c         = 1'b0;
      fall_c         = 1'b0;
      in_slot_c      = 1'b0;
      capture_c      = 1'b0;
      done_c         = 1'b0;
      bit_cnt_next_c = bit_cnt + 6'd1;
      word_c         = {shreg, sd_sync};
      real_c         = 16'($signed(word_c) >>> TRUNC);

      tick_c    = en && (div_cnt == DIV_LAST);
      rise_c    = tick_c && !bclk;
      fall_c    = tick_c && bclk;
      in_slot_c = (bit_cnt[5] == SLOT_SEL);
      // slot_pos 0 is the I2S one-bit delay; positions past SAMPLE_BITS are padding.
      capture_c = rise_c && in_slot_c &&
                  (bit_cnt[4:0] != 5'd0) && (bit_cnt[4:0] <= POS_LAST);
      done_c    = rise_c && in_slot_c && (bit_cnt[4:0] == POS_LAST);
   end

   // Bit clock, frame counter, word select and shift register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
         bit_cnt <= 6'd0;
         ws      <= 1'b0;
         shreg   <= '0;
      end else if (!en) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
         bit_cnt <= 6'd0;
         ws      <= 1'b0;
         shreg   <= '0;
      end else begin
         div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
         if (tick_c) begin
            bclk <= ~bclk;
         end
         // ws changes with bclk falling so the mic sees it one bit ahead of the MSB.
         if (fall_c) begin
            bit_cnt <= bit_cnt_next_c;
            ws      <= bit_cnt_next_c[5];
         end
         if (capture_c) begin
            shreg <= word_c[SAMPLE_BITS-2:0];
         end
      end
   end

`ifdef I2S_DC_BLOCK_EN

   logic [15:0] x_q;
   logic        x_valid;
   // DC estimate, signed, 10 fractional bits.
   logic [25:0] dc;

   logic [15:0] dc_int_c;
   logic [16:0] diff_c;
   logic [15:0] y_c;
   logic [26:0] err_c;
   logic [16:0] step_c;

   // y = x - (dc >>> 10) saturated; dc += ((x << 10) - dc) >>> 10.
   always_comb begin
      dc_int_c = dc[25:10];
      diff_c   = {x_q[15], x_q} - {dc_int_c[15], dc_int_c};
      y_c      = diff_c[15:0];
      err_c    = {x_q[15], x_q, 10'd0} - {dc[25], dc};
      step_c   = err_c[26:10];

      if (diff_c[16] != diff_c[15]) begin
         y_c = diff_c[16] ? 16'h8000 : 16'h7FFF;
      end
   end

   // Stage 1 latches the truncated sample, stage 2 filters it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q          <= 16'h0000;
         x_valid      <= 1'b0;
         dc           <= 26'd0;
         sample_out   <= 32'h0000_0000;
         sample_valid <= 1'b0;
      end else begin
         x_valid      <= done_c;
         sample_valid <= x_valid;
         if (done_c) begin
            x_q <= real_c;
         end
         if (x_valid) begin
            sample_out <= {y_c, 16'h0000};
            dc         <= dc + {{9{step_c[16]}}, step_c};
         end
      end
   end

`else

   // Truncated sample goes straight to the output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_out   <= 32'h0000_0000;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= done_c;
         if (done_c) begin
            sample_out <= {real_c, 16'h0000};
         end
      end
   end

`endif

endmodule

// File: tb/tb_i2s_sample_rx.sv
// tb_i2s_sample_rx
// Self-checking bench for i2s_sample_rx. Two instances share one microphone
// model: u_left captures the left slot, u_right the right slot. Stimulus
// pushes hand-computed expected words into per-instance queues; a monitor
// pops and compares whenever an instance pulses sample_valid.
`timescale 1ns/1ps

module tb_i2s_sample_rx;

   localparam int unsigned BCLK_DIV = 16;
   localparam int unsigned SB       = 18;
`ifdef I2S_DC_BLOCK_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        en    = 1'b0;
   logic        sd    = 1'b0;
   logic        dut_bclk  [2];
   logic        dut_ws    [2];
   logic [31:0] dut_out   [2];
   logic        dut_valid [2];

   i2s_sample_rx #(.BCLK_DIV(BCLK_DIV), .SAMPLE_BITS(SB), .CHANNEL(0)) u_left (
      .clk(clk), .reset(reset), .en(en), .sd(sd),
      .bclk(dut_bclk[0]), .ws(dut_ws[0]),
      .sample_out(dut_out[0]), .sample_valid(dut_valid[0]));

   i2s_sample_rx #(.BCLK_DIV(BCLK_DIV), .SAMPLE_BITS(SB), .CHANNEL(1)) u_right (
      .clk(clk), .reset(reset), .en(en), .sd(sd),
      .bclk(dut_bclk[1]), .ws(dut_ws[1]),
      .sample_out(dut_out[1]), .sample_valid(dut_valid[1]));

   always #5 clk = ~clk;

   int cmp_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, need %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame table: 18-bit left/right words and hand-truncated 16-bit results.
   logic [17:0] fl [8];
   logic [17:0] fr [8];
   logic [15:0] el [8];
   logic [15:0] er [8];
   int          fidx = 0;

   initial begin
      fl[0] = 18'h12345; fr[0] = 18'h3FFFC; el[0] = 16'h48D1; er[0] = 16'hFFFF;
      fl[1] = 18'h20000; fr[1] = 18'h00000; el[1] = 16'h8000; er[1] = 16'h0000;
      fl[2] = 18'h1FFFF; fr[2] = 18'h2AAAA; el[2] = 16'h7FFF; er[2] = 16'hAAAA;
      fl[3] = 18'h00000; fr[3] = 18'h3FFFC; el[3] = 16'h0000; er[3] = 16'hFFFF;
      fl[4] = 18'h3FFFF; fr[4] = 18'h12345; el[4] = 16'hFFFF; er[4] = 16'h48D1;
      fl[5] = 18'h2468A; fr[5] = 18'h13579; el[5] = 16'h0000; er[5] = 16'h0000;
      fl[6] = 18'h15555; fr[6] = 18'h0ABCD; el[6] = 16'h5555; er[6] = 16'h2AF3;
      fl[7] = 18'h00000; fr[7] = 18'h00000; el[7] = 16'h0000; er[7] = 16'h0000;
   end

   // Scoreboard queues and reference for the optional DC filter.
   logic [31:0] sbq0 [$];
   logic [31:0] sbq1 [$];
   logic [31:0] last_exp [2];
   int          dcm [2];

   function automatic logic [31:0] expect_word(input int c, input logic [15:0] x);
`ifdef I2S_DC_BLOCK_EN
      int xs;
      int y;
      xs = int'($signed(x));
      y  = xs - (dcm[c] >>> 10);
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      dcm[c] = dcm[c] + (((xs * 1024) - dcm[c]) >>> 10);
      return {y[15:0], 16'h0000};
`else
      if (c < 0) dcm[0] = 0;
      return {x, 16'h0000};
`endif
   endfunction

   task automatic push_frame(input int f);
      sbq0.push_back(expect_word(0, el[f]));
      sbq1.push_back(expect_word(1, er[f]));
   endtask

   // Microphone model and monitor, both sampled on the falling clk edge.
   int          cyc = 0;
   logic [5:0]  cnt = 6'd0;
   logic        bclk_q = 1'b0;
   logic        valid_q [2];
   int          wrap_count = 0;
   int          last_wrap = 0;
   int          last_rise = 0;
   bit          wrap_ok = 1'b0;
   bit          rise_ok = 1'b0;
   int          done_cyc [2];

   always @(negedge clk) begin
      logic [17:0] w;
      logic [31:0] e;
      int          p;
      cyc++;
      if (reset || !en) begin
         cnt     = 6'd0;
         sd      = 1'b0;
         wrap_ok = 1'b0;
         rise_ok = 1'b0;
      end else begin
         if (bclk_q && !dut_bclk[0]) begin
            cnt = cnt + 6'd1;
            check("ws_slot", 32'(dut_ws[0]), 32'(cnt[5]));
            if (cnt == 6'd0) begin
               wrap_count++;
               if (wrap_ok) check("ws_period", 32'(cyc - last_wrap), 32'd2048);
               last_wrap = cyc;
               wrap_ok   = 1'b1;
            end
            p = int'(cnt[4:0]);
            w = cnt[5] ? fr[fidx] : fl[fidx];
            sd = (p >= 1 && p <= int'(SB)) ? w[int'(SB) - p] : 1'b0;
         end
         if (!bclk_q && dut_bclk[0]) begin
            if (rise_ok) check("bclk_period", 32'(cyc - last_rise), 32'(2 * BCLK_DIV));
            last_rise = cyc;
            rise_ok   = 1'b1;
            if (int'(cnt[4:0]) == int'(SB)) done_cyc[cnt[5]] = cyc;
         end
      end
      bclk_q = dut_bclk[0];

      for (int c = 0; c < 2; c++) begin
         if (dut_valid[c]) begin
            check("valid_width", 32'(valid_q[c]), 32'd0);
            if ((c == 0 && sbq0.size() == 0) || (c == 1 && sbq1.size() == 0)) begin
               cmp_cnt++;
               err_cnt++;
               $display("FAIL unexpected_pulse: ch%0d got sample_valid with sample %0h, need no pulse (t=%0t)",
                        c, dut_out[c], $time);
            end else begin
               e = (c == 0) ? sbq0.pop_front() : sbq1.pop_front();
               check(c == 0 ? "sample_left" : "sample_right", dut_out[c], e);
               check("latency", 32'(cyc - done_cyc[c]), 32'(LAT));
               last_exp[c] = e;
            end
         end
         valid_q[c] = dut_valid[c];
      end
   end

   task automatic wait_wrap();
      int start;
      int n;
      start = wrap_count;
      n     = 0;
      while (wrap_count == start && n < 4300) begin
         @(negedge clk);
         n++;
      end
      check("wrap_timeout", 32'(wrap_count != start), 32'd1);
   endtask

   initial begin
      int n;
      valid_q[0] = 1'b0; valid_q[1] = 1'b0;
      done_cyc[0] = 0;   done_cyc[1] = 0;
      dcm[0] = 0;        dcm[1] = 0;
      last_exp[0] = 32'h0; last_exp[1] = 32'h0;
      reset = 1'b1;
      en    = 1'b0;

      repeat (4) @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         check("rst_bclk",  32'(dut_bclk[c]),  32'd0);
         check("rst_ws",    32'(dut_ws[c]),    32'd0);
         check("rst_out",   dut_out[c],        32'd0);
         check("rst_valid", 32'(dut_valid[c]), 32'd0);
      end

      @(posedge clk); #1;
      fidx = 0;
      push_frame(0);
      reset = 1'b0;
      en    = 1'b1;

      for (int f = 1; f <= 4; f++) begin
         wait_wrap();
         fidx = f;
         push_frame(f);
      end

      // Frame 5 is abandoned part-way through the left slot.
      wait_wrap();
      fidx = 5;
      n = 0;
      while (cnt != 6'd9 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("pos9_reached", 32'(cnt), 32'd9);
      @(posedge clk); #1;
      en = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         check("off_bclk", 32'(dut_bclk[c]), 32'd0);
         check("off_ws",   32'(dut_ws[c]),   32'd0);
      end
      repeat (100) @(negedge clk);
      check("hold_left",  dut_out[0], last_exp[0]);
      check("hold_right", dut_out[1], last_exp[1]);

      // Re-enable: the next full frame must come through intact.
      fidx = 6;
      push_frame(6);
      @(posedge clk); #1;
      en = 1'b1;
      wait_wrap();
      @(posedge clk); #1;
      en = 1'b0;

      repeat (50) @(negedge clk);
      check("left_drained",  32'(sbq0.size()), 32'd0);
      check("right_drained", 32'(sbq1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/i2s_sample_rx.md
# i2s_sample_rx

- Upstream front end of the FFT path.
- Generates I2S bit clock (`bclk`) and word select (`ws`) for a single MEMS microphone, and deserialises one channel.
- Presents each sample to the FFT frame loader as a 32-bit complex word: real in [31:16], imag zero. This is the `sample_in` / `sample_valid` pair.
- Runs entirely in the 48 MHz `clk` domain. `sample_valid` is a single-cycle pulse in that domain.

## Interface
Parameters:
- `BCLK_DIV`, 16: `bclk` half-period in `clk` cycles. Must be ≥2.
- `SAMPLE_BITS`, 18: significant bits per I2S slot, 16..24.
- `CHANNEL`, 0: slot captured. 0 = left (`ws`=0), 1 = right.

Ports:
- `clk`, in, 1: 48 MHz system clock.
- `reset`, in, 1: asynchronous, active-high.
- `en`, in, 1: run enable. Low holds the interface idle.
- `sd`, in, 1: serial data from the microphone, asynchronous.
- `bclk`, out, 1: I2S bit clock.
- `ws`, out, 1: I2S word select.
- `sample_out`, out, 32: {real[15:0], 16'h0000}.
- `sample_valid`, out, 1: one-`clk` pulse when `sample_out` is new.

## Operation
- Reset values: `bclk`=0, `ws`=0, `sample_out`=0, `sample_valid`=0, all counters 0, DC accumulator 0.
- `sd` passes through a 2-flop synchroniser before use.
- Divider `div_cnt` runs 0..BCLK_DIV-1 and wraps. When `div_cnt`==BCLK_DIV-1, `bclk` toggles.
- Rise event: `div_cnt`==BCLK_DIV-1 and `bclk`==0.
- Fall event: `div_cnt`==BCLK_DIV-1 and `bclk`==1.
- `bit_cnt` (6 bits, 0..63) increments mod 64 on each fall event.
  - `ws` is registered from the new `bit_cnt[5]` on that same edge.
  - Slot = `bit_cnt[5]`. `slot_pos` = `bit_cnt[4:0]`.
- Capture:
  - On a rise event with slot==CHANNEL and `slot_pos` in 1..SAMPLE_BITS, shift the synchronised `sd` into `shreg` MSB-first.
  - `slot_pos` 0 is the I2S one-bit delay and is ignored.
  - Bits beyond SAMPLE_BITS are ignored.
- Completion: on the rise event with `slot_pos`==SAMPLE_BITS, the word is complete.
  - real = `shreg` arithmetically shifted right by SAMPLE_BITS-16. This is truncation, not rounding.
  - `sample_out` is loaded and `sample_valid` pulses.
- Exactly one `sample_valid` per 64-bit frame.
- `en` low:
  - At the next `clk` edge, `div_cnt`, `bit_cnt` and `shreg` clear, and `bclk` and `ws` drive 0.
  - A partial sample is discarded and no pulse is issued.
  - `sample_out` holds its last value.
- `en` rising: the frame restarts at `bit_cnt`=0 with the left slot. The first valid arrives after a full slot has been received.
- `reset` mid-frame: immediate return to reset values. No pulse is generated.

## Timing
- Sample rate = f_clk / (2·BCLK_DIV·64). Default: 48 MHz / 2048 = 23 437.5 Hz.
- `bclk` = 1.5 MHz at default.
- Synchroniser delay is 2 `clk`. `sd` is stable for ≥BCLK_DIV-2 `clk` after a mic fall edge, so it is valid at the rise event.
- Latency without the macro: `sample_valid` and the new `sample_out` are visible 1 `clk` after the rise event capturing the last bit.
- `sample_valid` is high for exactly 1 `clk`.
- `sample_out` remains stable until the next pulse, which arrives 2048 `clk` later at default settings.

## Configuration
- `I2S_DC_BLOCK_EN` defined:
  - Adds a first-order DC-removal filter between truncation and output.
  - 26-bit signed accumulator `dc` holds the estimate with 10 fractional bits.
  - Output y = x − (`dc`>>>10), saturated to [−32768, 32767].
  - Update: `dc` += (x<<10 − `dc`)>>>10.
  - Adds exactly 1 `clk` latency, so `sample_valid` appears 2 `clk` after the final rise event.
  - The filter updates only on completed samples. `dc` is not cleared by `en` low; it is cleared by `reset`.
- `I2S_DC_BLOCK_EN` undefined: the filter is absent, latency is 1 `clk`, and the truncated x passes straight through.

## Test plan
- Reset then `en`=1, BCLK_DIV=16 → all outputs 0 during reset; `bclk` period 32 `clk`; `ws` period 2048 `clk`; `ws` toggles coincident with `bclk` falling.
- Mic model, left slot 18'h12345, CHANNEL=0 → `sample_out`=32'h48D1_0000 with a single 1-`clk` `sample_valid` per frame; right-slot data has no effect.
- Left slot 18'h20000 → `sample_out`=32'h8000_0000. Left slot 18'h1FFFF → 32'h7FFF_0000.
- CHANNEL=1, left 18'h00000, right 18'h3FFFC → `sample_out`=32'hFFFF_0000.
- `en` dropped at `slot_pos` 9 of the left slot → `bclk` and `ws` low within 1 `clk`; no pulse. On re-enable, the first pulse comes after the next full left slot, with the correct value.
- With `I2S_DC_BLOCK_EN`, constant input yielding x=16'h1000 → first output 16'h1000 (`dc` still 0), then monotonically decaying; |y| < 16 after 8192 samples; no overflow.
